// File: rtl/change_dispenser.sv
// Greedy coin refund engine: pays a half-yuan amount out through a hopper as 10 / 1 / 0.5 yuan coins.
// One coin per request/acknowledge handshake, followed by a fixed idle gap; a missing ack latches a sticky fault.
module change_dispenser #(
  parameter int unsigned ACK_TIMEOUT = 200,
  parameter int unsigned GAP_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       charge_ind,
  input  logic [5:0] coin_sum,
  input  logic       hopper_ack,
  output logic       eject_req,
  output logic [1:0] coin_sel,
  output logic       busy,
  output logic [5:0] remain,
  output logic       done,
  output logic       fault
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_REQ    = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_1Y   = 2'b01;
  localparam logic [1:0] SEL_10Y  = 2'b10;
  localparam logic [1:0] SEL_05Y  = 2'b11;

  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  logic [2:0] state;
  logic       charge_q;
  logic [5:0] remain_q;
  logic [1:0] sel_q;
  logic [7:0] tmo_cnt;
  logic [3:0] gap_cnt;

  logic       req_edge;
  logic [5:0] clamp_sum;
  logic [1:0] next_sel;
  logic [5:0] coin_val;

  assign req_edge  = charge_ind & ~charge_q;
  assign clamp_sum = (coin_sum > 6'd40) ? 6'd40 : coin_sum;

  // Greedy choice guarantees the chosen coin never exceeds what is left to pay.
  always_comb begin
    next_sel = SEL_05Y;
    if (remain_q >= 6'd20)
      next_sel = SEL_10Y;
    else if (remain_q >= 6'd2)
      next_sel = SEL_1Y;
  end

  always_comb begin
    coin_val = 6'd0;
    case (sel_q)
      SEL_10Y: coin_val = 6'd20;
      SEL_1Y:  coin_val = 6'd2;
      SEL_05Y: coin_val = 6'd1;
      default: coin_val = 6'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      charge_q <= 1'b0;
      remain_q <= 6'd0;
      sel_q    <= SEL_NONE;
      tmo_cnt  <= 8'd0;
      gap_cnt  <= 4'd0;
    end else begin
      charge_q <= charge_ind;
      case (state)
        S_IDLE: begin
          if (req_edge) begin
            remain_q <= clamp_sum;
            state    <= (clamp_sum != 6'd0) ? S_SELECT : S_DONE;
          end
        end
        S_SELECT: begin
          sel_q   <= next_sel;
          tmo_cnt <= 8'd0;
          state   <= S_REQ;
        end
        S_REQ: begin
          // An ack arriving on the last allowed cycle still counts as success.
          if (hopper_ack) begin
            remain_q <= remain_q - coin_val;
            gap_cnt  <= 4'd0;
            state    <= S_GAP;
          end else if (tmo_cnt == TMO_LAST) begin
            state <= S_FAULT;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (remain_q != 6'd0) begin
              state <= S_SELECT;
            end else begin
              sel_q <= SEL_NONE;
              state <= S_DONE;
            end
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_FAULT: state <= S_FAULT;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Decoded straight from state so an asynchronous reset drops the request at once.
  assign eject_req = (state == S_REQ);
  assign busy      = (state == S_SELECT) || (state == S_REQ) || (state == S_GAP);
  assign done      = (state == S_DONE);
  assign fault     = (state == S_FAULT);
  assign coin_sel  = sel_q;
  assign remain    = remain_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with a scoreboard of expected coins built from a greedy model.
module tb_change_dispenser;

  localparam int ACK_TO = 10;
  localparam int GAP    = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       charge_ind;
  logic [5:0] coin_sum;
  logic       hopper_ack;
  logic       eject_req;
  logic [1:0] coin_sel;
  logic       busy;
  logic [5:0] remain;
  logic       done;
  logic       fault;

  typedef struct {
    logic [1:0] sel;
    logic [5:0] rem_after;
  } coin_t;

  coin_t exp_q[$];
  int    n_assert = 0;
  int    n_fail   = 0;

  change_dispenser #(.ACK_TIMEOUT(ACK_TO), .GAP_CYCLES(GAP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .charge_ind (charge_ind),
    .coin_sum   (coin_sum),
    .hopper_ack (hopper_ack),
    .eject_req  (eject_req),
    .coin_sel   (coin_sel),
    .busy       (busy),
    .remain     (remain),
    .done       (done),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] all_outs();
    return {eject_req, coin_sel, busy, remain, done, fault};
  endfunction

  // Greedy model of the coin sequence for a requested amount.
  task automatic push_expected(input logic [5:0] amt);
    int    a;
    coin_t c;
    a = (amt > 6'd40) ? 40 : int'(amt);
    while (a != 0) begin
      if (a >= 20) begin
        c.sel = 2'b10; a -= 20;
      end else if (a >= 2) begin
        c.sel = 2'b01; a -= 2;
      end else begin
        c.sel = 2'b11; a -= 1;
      end
      c.rem_after = 6'(a);
      exp_q.push_back(c);
    end
  endtask

  // Leaves the bench in the SELECT cycle (k+1) after a fresh request edge.
  task automatic start_refund(input logic [5:0] amt, input bit hold);
    logic [5:0] clamped;
    clamped    = (amt > 6'd40) ? 6'd40 : amt;
    charge_ind = 1'b0;
    tick();
    coin_sum   = amt;
    charge_ind = 1'b1;
    push_expected(amt);
    tick();
    chk("select_busy", busy, 1'b1);
    chk("select_remain", remain, clamped);
    chk("select_no_req", eject_req, 1'b0);
    if (!hold) charge_ind = 1'b0;
  endtask

  // Acks each requested coin one cycle after eject_req rises; noisy injects busy-time disturbances.
  task automatic run_coins(input bit noisy);
    coin_t e;
    bit    first;
    bit    found;
    int    low;
    first = 1'b1;
    low   = 1;
    while (exp_q.size() > 0) begin
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (eject_req) begin
          found = 1'b1;
          break;
        end
        low++;
      end
      if (!found) begin
        chk("wait_eject_timeout", 32'd0, 32'd1);
        exp_q.delete();
        return;
      end
      if (!first) chk("gap_low_cycles", low, GAP + 1);
      e = exp_q.pop_front();
      chk("coin_sel", coin_sel, e.sel);
      tick();
      chk("req_hold", {eject_req, coin_sel}, {1'b1, e.sel});
      hopper_ack = 1'b1;
      tick();
      hopper_ack = 1'b0;
      chk("ack_drop_req", eject_req, 1'b0);
      chk("ack_remain", remain, e.rem_after);
      low = 1;
      if (noisy && first) begin
        hopper_ack = 1'b1;
        coin_sum   = 6'd30;
        tick();
        hopper_ack = 1'b0;
        chk("gap_ack_ignored", remain, e.rem_after);
        low++;
      end
      first = 1'b0;
    end
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) begin
        found = 1'b1;
        break;
      end
      low++;
    end
    chk("done_seen", found, 1'b1);
    chk("done_latency", low, GAP);
    chk("done_state", {busy, coin_sel, remain, fault, eject_req}, 11'd0);
    tick();
    chk("done_one_pulse", {done, busy}, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired n_assert=%0d", n_assert);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    charge_ind = 1'b0;
    coin_sum   = 6'd0;
    hopper_ack = 1'b0;
    tick();
    tick();
    chk("reset_outputs", all_outs(), 12'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_outputs", all_outs(), 12'd0);

    // Mixed greedy refund: 23 -> 3 -> 1 -> 0
    start_refund(6'd23, 1'b0);
    run_coins(1'b0);

    // Maximum amount and clamp above it
    start_refund(6'd40, 1'b0);
    run_coins(1'b0);
    start_refund(6'd50, 1'b0);
    run_coins(1'b0);

    // Zero refund: done at k+1, no request, never busy
    charge_ind = 1'b0;
    tick();
    coin_sum   = 6'd0;
    charge_ind = 1'b1;
    tick();
    chk("zero_done", {done, busy, eject_req}, 3'b100);
    tick();
    chk("zero_after", {done, busy, eject_req}, 3'b000);
    charge_ind = 1'b0;

    // Inputs during busy: charge held high, coin_sum changed, ack pulsed in GAP
    start_refund(6'd6, 1'b1);
    run_coins(1'b1);
    for (int i = 0; i < 3; i++) tick();
    chk("no_restart_busy", {busy, eject_req, done}, 3'b000);
    charge_ind = 1'b0;

    // Reset mid-REQ, then a fresh refund
    start_refund(6'd23, 1'b0);
    tick();
    chk("pre_reset_req", eject_req, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outs", all_outs(), 12'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    start_refund(6'd4, 1'b0);
    run_coins(1'b0);

    // Hopper timeout with ack withheld
    start_refund(6'd4, 1'b0);
    begin
      int hi;
      hi = 0;
      exp_q.delete();
      for (int i = 0; i < 50; i++) begin
        tick();
        if (!eject_req) break;
        hi++;
      end
      chk("timeout_req_cycles", hi, ACK_TO);
    end
    chk("fault_set", {fault, busy, eject_req}, 3'b100);
    chk("fault_remain", remain, 6'd4);
    tick();
    charge_ind = 1'b1;
    tick();
    tick();
    chk("fault_sticky_edge", {fault, busy, eject_req, remain}, {3'b100, 6'd4});
    charge_ind = 1'b0;
    rst_n = 1'b0;
    #1 chk("fault_cleared_by_reset", all_outs(), 12'd0);
    tick();
    rst_n = 1'b1;
    start_refund(6'd2, 1'b0);
    run_coins(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Downstream stage of the vending controller FSM. It consumes the refund request (`charge_ind` level) and the coin total (`coin_sum`, Q1 half-yuan units). It pays the amount out through a coin hopper as a greedy sequence of 10-yuan, 1-yuan and 0.5-yuan coins, using a per-coin request/acknowledge handshake with an acknowledge timeout. It reports progress with `busy`, `remain` and `done`, and reports hopper failure with `fault`.

## Interface
- `ACK_TIMEOUT`, default 200: cycles `eject_req` may stay high without `hopper_ack` before `fault`. Range 1..255.
- `GAP_CYCLES`, default 4: idle cycles after each acknowledged coin. Range 1..15.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock; all state changes on posedge.
- `rst_n`  in  1  asynchronous active-low reset.
- `charge_ind`  in  1  refund request level from the controller FSM.
- `coin_sum`  in  6  amount to refund, half-yuan units (x*2). Sampled only at request edge.
- `hopper_ack`  in  1  hopper has ejected the requested coin. Sampled at posedge.
- `eject_req`  out  1  coin request to hopper.
- `coin_sel`  out  2  coin type: 2'b10 = 10 yuan, 2'b01 = 1 yuan, 2'b11 = 0.5 yuan, 2'b00 = none.
- `busy`  out  1  refund in progress.
- `remain`  out  6  amount still to pay, half-yuan units.
- `done`  out  1  one-cycle pulse when a refund completes.
- `fault`  out  1  sticky hopper timeout flag.

## Operation
- **Reset.** While `rst_n` is low, every output is 0, state is IDLE, and the edge-detect register and counters are 0.
- **Request edge.** A request edge is `charge_ind`=1 with the registered previous `charge_ind`=0. Edges are ignored outside IDLE.
- **IDLE** (`busy`=0). On a request edge:
  - latch `remain` = min(`coin_sum`, 40);
  - if the latched value ≠ 0, go to SELECT; otherwise go to DONE.
- **SELECT** (`busy`=1). Set `coin_sel` from `remain`:
  - `remain` ≥ 20 → 10 yuan;
  - `remain` ≥ 2 → 1 yuan;
  - otherwise → 0.5 yuan.
  - Clear the timeout counter, then go to REQ.
- **REQ**. `eject_req`=1 and `coin_sel` is held stable.
  - On `hopper_ack`=1: subtract the coin value from `remain` (20, 2 or 1). Go to GAP.
  - Otherwise increment the timeout counter. When it reaches `ACK_TIMEOUT`, go to FAULT.
  - An ack in the same cycle as the timeout wins.
- **GAP**. `eject_req`=0 for `GAP_CYCLES` cycles. Then go to SELECT if `remain` ≠ 0, else DONE.
- **DONE**. `done`=1 for exactly one cycle. `coin_sel`=0, `busy`=0. Go to IDLE.
- **FAULT**. `fault`=1, `eject_req`=0, `busy`=0, `remain` is held.
  - FAULT exits only via `rst_n`.
- **Ack outside REQ.** `hopper_ack` outside REQ is ignored.
- **Arithmetic.** `remain` never underflows, because the greedy selection guarantees coin value ≤ `remain`.

## Timing
- **Latency from request edge.** Let `charge_ind` rise in cycle k.
  - `remain` is valid in cycle k+1 (SELECT).
  - `eject_req` is first high in cycle k+2.
- **Ack.** `hopper_ack` high in REQ cycle j → `eject_req`=0 and `remain` updated in cycle j+1.
- **Between coins.** `eject_req` is low for `GAP_CYCLES`+1 cycles between consecutive coins (GAP plus SELECT).
- **Completion.** The last GAP ends in cycle m → `done` is high in cycle m+1 and IDLE starts in m+2.
- **Zero refund.** `remain`=0 at the request edge → `done` in cycle k+1, with no `eject_req`.
- **Timeout.** With no ack, REQ lasts `ACK_TIMEOUT` cycles. `fault` rises the following cycle.
- **Request during busy.** `charge_ind` held high, or re-asserted while busy, never restarts a refund. A new refund needs a low-to-high transition seen in IDLE.
- **Input changes.** `coin_sum` changes after the request edge have no effect.
- **Reset mid-refund.** Asserting `rst_n` mid-refund clears `eject_req` asynchronously, within the same cycle. No partial decrement is retained.

## Test plan
- **Mixed greedy refund.** `coin_sum`=23, `hopper_ack` asserted one cycle after each `eject_req`. Expect:
  - `coin_sel` sequence 10, 01, 11;
  - `remain` 23→3→1→0;
  - exactly one `done` pulse and `fault`=0.
- **Maximum amount.** `coin_sum`=40. Expect two 10-yuan requests, `remain` 40→20→0, then `done`. Also check `coin_sum`=50 clamps to 40 with the same sequence.
- **Zero refund.** `coin_sum`=0, `charge_ind` rises in cycle k. Expect `done` in cycle k+1, `eject_req` never high, `busy` stays 0.
- **Hopper timeout.** `ACK_TIMEOUT`=10, ack withheld, `coin_sum`=4. Expect:
  - `eject_req` high for 10 cycles, then 0;
  - `fault`=1 sticky and `remain`=4 held;
  - a later `charge_ind` edge ignored until `rst_n` is pulsed.
- **Inputs during busy.** While busy, hold `charge_ind` high, change `coin_sum` to 30, and pulse `hopper_ack` during GAP. Expect:
  - no restart and no extra decrement;
  - refund completes for the originally latched value.
- **Reset mid-REQ.** Drop `rst_n` while in REQ. Expect all outputs 0 immediately. After release, the next request edge behaves like a fresh refund.
